// File: rtl/haar_pkg.sv
// Shared types and default sizes for the multi-lane Haar stage-decision controller.
package haar_pkg;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_SUM_W     = 32;
  localparam int DEF_STAGE_CNT = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  typedef logic signed [DEF_SUM_W-1:0] sum_t;
  typedef logic [DEF_NUM_LANES-1:0]    lane_mask_t;
  typedef sum_t [DEF_NUM_LANES-1:0]    lane_sum_t;

endpackage

// File: rtl/haar_lane_acc.sv
// One lane's signed vote accumulator and its stage-threshold comparator.
module haar_lane_acc
  import haar_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [SUM_W-1:0] vote,
  input  logic signed [SUM_W-1:0] threshold,
  output logic                    pass
);

  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] sum;

  // The compare sees a vote arriving in the same cycle as the threshold.
  assign sum  = en ? acc + vote : acc;
  assign pass = sum >= threshold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clear) acc <= '0;
    else            acc <= sum;
  end

endmodule

// File: rtl/haar_multi_lane_stage_ctrl.sv
// Stage-decision controller evaluating NUM_LANES Haar windows in lockstep.
// Optional HAAR_LANE_STAGE_EN adds lane_stage_o, the per-lane rejection stage.
module haar_multi_lane_stage_ctrl
  import haar_pkg::*;
#(
  parameter int NUM_LANES            = DEF_NUM_LANES,
  parameter int SUM_W                = DEF_SUM_W,
  parameter int STAGE_CLASSIFIER_CNT = DEF_STAGE_CNT,
  parameter int STAGE_W              = $clog2(STAGE_CLASSIFIER_CNT + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             start_i,
  input  logic [NUM_LANES-1:0]             lane_en_i,
  input  logic                             vote_val_i,
  output logic                             vote_rdy_o,
  input  logic [NUM_LANES-1:0][SUM_W-1:0]  vote_i,
  input  logic [SUM_W-1:0]                 stage_threshold_i,
  input  logic                             stage_threshold_val_i,
  input  logic                             stage_last_i,
  output logic                             next_stage_o,
  output logic                             break_o,
  output logic                             done_o,
  output logic [NUM_LANES-1:0]             result_o,
  output logic [NUM_LANES-1:0]             alive_o,
  output logic [STAGE_W-1:0]               stage_idx_o,
  output logic                             busy_o
`ifdef HAAR_LANE_STAGE_EN
  ,
  output logic [NUM_LANES-1:0][STAGE_W-1:0] lane_stage_o
`endif
);

  state_t               state, state_nxt;
  logic                 start_ok, thr_hit, last_stage, clear_acc;
  logic                 done_nxt, break_nxt, next_nxt;
  logic [NUM_LANES-1:0] pass, acc_en, alive_nxt, result_nxt;

  assign vote_rdy_o = (state == ACCUM);
  assign start_ok   = (state == IDLE) && start_i && !busy_o;
  assign thr_hit    = (state == ACCUM) && stage_threshold_val_i;
  assign alive_nxt  = alive_o & pass;
  assign last_stage = stage_last_i ||
                      (stage_idx_o == STAGE_W'(STAGE_CLASSIFIER_CNT - 1));
  assign clear_acc  = start_ok || next_stage_o;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign acc_en[l] = vote_rdy_o && vote_val_i && alive_o[l];

    haar_lane_acc #(.SUM_W(SUM_W)) u_acc (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .clear     (clear_acc),
      .en        (acc_en[l]),
      .vote      (vote_i[l]),
      .threshold (stage_threshold_i),
      .pass      (pass[l])
    );
  end

  // The decision is computed at the threshold beat so that every pulse
  // leaves a register in the DECIDE cycle.
  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    break_nxt  = 1'b0;
    next_nxt   = 1'b0;
    result_nxt = result_o;
    case (state)
      IDLE: begin
        if (start_ok) begin
          result_nxt = '0;
          if (lane_en_i == '0) done_nxt  = 1'b1;
          else                 state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (stage_threshold_val_i) begin
          state_nxt = DECIDE;
          if (alive_nxt == '0) begin
            break_nxt  = 1'b1;
            done_nxt   = 1'b1;
            result_nxt = '0;
          end else if (last_stage) begin
            done_nxt   = 1'b1;
            result_nxt = alive_nxt;
          end else begin
            next_nxt   = 1'b1;
          end
        end
      end
      DECIDE:  state_nxt = next_stage_o ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      done_o       <= 1'b0;
      break_o      <= 1'b0;
      next_stage_o <= 1'b0;
      result_o     <= '0;
      alive_o      <= '0;
      stage_idx_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_o       <= done_nxt;
      break_o      <= break_nxt;
      next_stage_o <= next_nxt;
      result_o     <= result_nxt;
      if (start_ok)     alive_o <= lane_en_i;
      else if (thr_hit) alive_o <= alive_nxt;
      if (start_ok)          stage_idx_o <= '0;
      else if (next_stage_o) stage_idx_o <= stage_idx_o + 1'b1;
      if (start_ok)    busy_o <= 1'b1;
      else if (done_o) busy_o <= 1'b0;
    end
  end

`ifdef HAAR_LANE_STAGE_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lane_stage_o <= '0;
    end else if (start_ok) begin
      lane_stage_o <= '0;
    end else if (thr_hit) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (alive_o[l] && !pass[l])
          lane_stage_o[l] <= stage_idx_o;
        else if (alive_nxt[l] && last_stage)
          lane_stage_o[l] <= STAGE_W'(STAGE_CLASSIFIER_CNT);
      end
    end
  end
`endif

  // A vote offered while the controller is not accepting is lost.
  a_vote_only_in_accum : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) vote_val_i |-> (state == ACCUM)
  ) else $error("vote_val_i asserted outside ACCUM");

endmodule

// File: tb/tb_haar_multi_lane_stage_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and a random run against a lane model.
module tb_haar_multi_lane_stage_ctrl;

  localparam int NL  = 4;
  localparam int SW  = 32;
  localparam int CNT = 22;
  localparam int STW = 5;

  logic                    clk = 1'b0;
  logic                    rst_n, start, vote_val, vote_rdy, thr_val, last;
  logic                    next_stage, brk, done, busy;
  logic [NL-1:0]           lane_en, result, alive;
  logic [NL-1:0][SW-1:0]   vote;
  logic [SW-1:0]           thr;
  logic [STW-1:0]          stage_idx;
`ifdef HAAR_LANE_STAGE_EN
  logic [NL-1:0][STW-1:0]  lane_stage;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  haar_multi_lane_stage_ctrl dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .start_i               (start),
    .lane_en_i             (lane_en),
    .vote_val_i            (vote_val),
    .vote_rdy_o            (vote_rdy),
    .vote_i                (vote),
    .stage_threshold_i     (thr),
    .stage_threshold_val_i (thr_val),
    .stage_last_i          (last),
    .next_stage_o          (next_stage),
    .break_o               (brk),
    .done_o                (done),
    .result_o              (result),
    .alive_o               (alive),
    .stage_idx_o           (stage_idx),
    .busy_o                (busy)
`ifdef HAAR_LANE_STAGE_EN
    ,
    .lane_stage_o          (lane_stage)
`endif
  );

  typedef struct packed {
    logic [3:0]        en;
    logic [3:0][31:0]  v0;
    logic [3:0][31:0]  v1;
    logic [31:0]       thr;
    logic [3:0]        exp_res;
    logic              exp_brk;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [3:0][31:0] lanes4(int a0, int a1, int a2, int a3);
    logic [3:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  function automatic vec_t mk(logic [3:0] en, logic [3:0][31:0] v0, logic [3:0][31:0] v1,
                              int t, logic [3:0] res, logic b);
    vec_t r;
    r.en = en; r.v0 = v0; r.v1 = v1; r.thr = t; r.exp_res = res; r.exp_brk = b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_eval(input logic [3:0] en);
    start = 1'b1;
    lane_en = en;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic vv, input logic [3:0][31:0] v, input logic tv,
                                input logic [31:0] t, input logic lst);
    vote_val = vv; vote = v; thr_val = tv; thr = t; last = lst;
    tick();
    vote_val = 1'b0; thr_val = 1'b0; last = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [3:0] en_r, m_alive;
    logic [3:0][31:0] v;
    logic use_vote, fin;
    int m_acc [4];
    int nst, nb, rv, t;

    tbl[0] = mk(4'b1111, lanes4(6, 6, 4, 12), lanes4(5, 3, 5, -1), 10, 4'b1001, 1'b0);
    tbl[1] = mk(4'b1111, lanes4(8, 8, 8, 8), lanes4(3, 2, 4, 3), 11, 4'b1101, 1'b0);
    tbl[2] = mk(4'b0101, lanes4(-5, 100, -20, 100), lanes4(-5, 100, -1, 100), -10, 4'b0001, 1'b0);
    tbl[3] = mk(4'b1111, lanes4(0, 0, 0, 0), lanes4(0, 0, 0, 0), 1, 4'b0000, 1'b1);
    tbl[4] = mk(4'b1111, lanes4(32'sh7FFFFFFF, -1, 5, 32'sh80000000), lanes4(1, 1, -5, -1),
                0, 4'b1110, 1'b0);
    tbl[5] = mk(4'b1000, lanes4(0, 0, 0, 50), lanes4(0, 0, 0, -50), 0, 4'b1000, 1'b0);

    rst_n = 1'b0; start = 1'b0; lane_en = '0; vote_val = 1'b0; vote = '0;
    thr = '0; thr_val = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", 32'({vote_rdy, next_stage, brk, done, busy, result, alive, stage_idx}), 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-ACCUM must clear everything at once and never produce done.
    start_eval(4'b1111);
    apply_stimulus(1'b1, lanes4(3, 3, 3, 3), 1'b0, 0, 1'b0);
    check_output("pre_reset_rdy", 32'(vote_rdy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_reset_outputs", 32'({vote_rdy, next_stage, brk, done, busy, result, alive, stage_idx}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("post_reset_idle", 32'({done, busy, vote_rdy}), 0);
    end

    // Single-stage evaluations from the vector table.
    for (int i = 0; i < 6; i++) begin
      start_eval(tbl[i].en);
      check_output($sformatf("tbl%0d_alive_start", i), 32'(alive), 32'(tbl[i].en));
      apply_stimulus(1'b1, tbl[i].v0, 1'b0, 0, 1'b0);
      apply_stimulus(1'b1, tbl[i].v1, 1'b1, tbl[i].thr, 1'b1);
      check_output($sformatf("tbl%0d_done", i), 32'(done), 1);
      check_output($sformatf("tbl%0d_break", i), 32'(brk), 32'(tbl[i].exp_brk));
      check_output($sformatf("tbl%0d_next", i), 32'(next_stage), 0);
      check_output($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].exp_res));
      check_output($sformatf("tbl%0d_alive", i), 32'(alive), 32'(tbl[i].exp_res));
      tick();
      check_output($sformatf("tbl%0d_busy_low", i), 32'(busy), 0);
    end

    // Two stages: first non-last stage leaves lanes 0 and 3 alive.
    start_eval(4'b1111);
    apply_stimulus(1'b1, lanes4(6, 6, 4, 12), 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, lanes4(5, 3, 5, -1), 1'b1, 10, 1'b0);
    check_output("two_next_stage", 32'({next_stage, done, brk}), 32'b100);
    check_output("two_alive_s1", 32'(alive), 32'b1001);
    tick();
    check_output("two_stage_idx", 32'(stage_idx), 1);
    check_output("two_rdy", 32'(vote_rdy), 1);
    apply_stimulus(1'b1, lanes4(20, 20, 20, 20), 1'b1, 10, 1'b1);
    check_output("two_done", 32'({next_stage, done, brk}), 32'b010);
    check_output("two_result", 32'(result), 32'b1001);
`ifdef HAAR_LANE_STAGE_EN
    check_output("two_lane_stage", 32'(lane_stage), 32'({5'd22, 5'd0, 5'd0, 5'd22}));
`endif
    tick();

    // All lanes rejected at the third stage.
    start_eval(4'b1111);
    for (int s = 0; s < 3; s++) begin
      rv = (s < 2) ? 5 : -5;
      apply_stimulus(1'b1, lanes4(rv, rv, rv, rv), 1'b1, 0, 1'b0);
      if (s < 2) begin
        check_output("fail3_next", 32'(next_stage), 1);
        tick();
      end
    end
    check_output("fail3_break_done", 32'({brk, done, next_stage}), 32'b110);
    check_output("fail3_result", 32'(result), 0);
    check_output("fail3_stage_idx", 32'(stage_idx), 2);
`ifdef HAAR_LANE_STAGE_EN
    check_output("fail3_lane_stage", 32'(lane_stage), 32'({5'd2, 5'd2, 5'd2, 5'd2}));
`endif
    tick();

    // stage_last never asserted: the final stage index forces completion.
    start_eval(4'b1011);
    for (int s = 0; s < CNT; s++) begin
      apply_stimulus(1'b1, lanes4(1, 1, 1, 1), 1'b1, 0, 1'b0);
      if (s < CNT - 1) begin
        check_output($sformatf("forced_s%0d", s), 32'({next_stage, done}), 32'b10);
        tick();
      end
    end
    check_output("forced_done", 32'({next_stage, done, brk}), 32'b010);
    check_output("forced_result", 32'(result), 32'b1011);
    check_output("forced_stage_idx", 32'(stage_idx), CNT - 1);
`ifdef HAAR_LANE_STAGE_EN
    check_output("forced_lane_stage", 32'(lane_stage), 32'({5'd22, 5'd0, 5'd22, 5'd22}));
`endif
    tick();

    // No enabled lanes: done next cycle without break; a start while busy is ignored.
    start_eval(4'b0000);
    check_output("empty_done", 32'({done, brk, busy}), 32'b101);
    check_output("empty_result", 32'(result), 0);
    start = 1'b1; lane_en = 4'b1111;
    tick();
    start = 1'b0;
    check_output("busy_start_ignored", 32'({busy, vote_rdy, done}), 0);
    start_eval(4'b0011);
    start = 1'b1; lane_en = 4'b1100;
    tick();
    start = 1'b0;
    check_output("accum_start_ignored", 32'(alive), 32'b0011);
    apply_stimulus(1'b0, lanes4(0, 0, 0, 0), 1'b1, -100, 1'b1);
    check_output("accum_start_result", 32'({done, result}), 32'b10011);
    tick();

    // Random multi-stage evaluations against the lane model.
    for (int it = 0; it < 25; it++) begin
      en_r = 4'($urandom_range(1, 15));
      nst = $urandom_range(1, 4);
      start_eval(en_r);
      m_alive = en_r;
      for (int s = 0; s < nst; s++) begin
        for (int l = 0; l < 4; l++) m_acc[l] = 0;
        nb = $urandom_range(1, 3);
        t = 0;
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) tick();
          fin = (b == nb - 1);
          use_vote = fin ? 1'($urandom_range(0, 1)) : 1'b1;
          for (int l = 0; l < 4; l++) begin
            rv = int'($urandom_range(0, 40)) - 20;
            v[l] = rv;
            if (use_vote && m_alive[l]) m_acc[l] += rv;
          end
          t = int'($urandom_range(0, 40)) - 15;
          apply_stimulus(use_vote, v, fin, t, fin && (s == nst - 1));
        end
        for (int l = 0; l < 4; l++)
          if (m_acc[l] < t) m_alive[l] = 1'b0;
        check_output($sformatf("rnd%0d_s%0d_alive", it, s), 32'(alive), 32'(m_alive));
        if (m_alive == '0) begin
          check_output($sformatf("rnd%0d_s%0d_break", it, s), 32'({brk, done, next_stage, result}), 32'b1100000);
          tick();
          break;
        end else if (s == nst - 1) begin
          check_output($sformatf("rnd%0d_s%0d_final", it, s), 32'({brk, done, next_stage, result}),
                       32'({3'b010, m_alive}));
          tick();
        end else begin
          check_output($sformatf("rnd%0d_s%0d_next", it, s), 32'({brk, done, next_stage}), 32'b001);
          tick();
          check_output($sformatf("rnd%0d_s%0d_idx", it, s), 32'(stage_idx), 32'(s + 1));
        end
      end
      check_output($sformatf("rnd%0d_idle", it), 32'({busy, vote_rdy}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
